// File: rtl/uart_tx_fifo.sv
// Byte-wide UART transmitter (8N1, LSB first) fed through a small circular FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 52,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    shift, shift_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic          ser_nxt;
  logic          push, pop, bit_done;
`ifdef UART_TX_PARITY_EN
  logic          par, par_nxt;
`endif

  assign in_ready   = (count != (AW+1)'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign bit_done   = (cnt == '0);
  assign busy       = (state != S_IDLE) || (count != '0);
  assign fifo_count = count;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    ser_nxt   = ser_tx;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    if (state != S_IDLE)
      cnt_nxt = bit_done ? CNT_RELOAD : cnt - 1'b1;
    case (state)
      S_IDLE: begin
        ser_nxt = 1'b1;
        pop     = (count != '0);
      end
      S_START: begin
        if (bit_done) begin
          ser_nxt   = shift[0];
          shift_nxt = shift >> 1;
          idx_nxt   = 3'd0;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            ser_nxt   = par;
            state_nxt = S_PARITY;
`else
            ser_nxt   = 1'b1;
            state_nxt = S_STOP;
`endif
          end else begin
            ser_nxt   = shift[0];
            shift_nxt = shift >> 1;
            idx_nxt   = idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          ser_nxt   = 1'b1;
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          pop       = (count != '0);
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Launching a frame from IDLE or straight out of STOP (no idle gap)
    if (pop) begin
      shift_nxt = mem[rd_ptr];
      ser_nxt   = 1'b0;
      cnt_nxt   = CNT_RELOAD;
      state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
      par_nxt   = ^mem[rd_ptr];
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      ser_tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      ser_tx <= ser_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Datapath storage carries no reset; its contents are qualified by the control state
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
    shift <= shift_nxt;
`ifdef UART_TX_PARITY_EN
    par   <= par_nxt;
`endif
  end

endmodule
